irq_vector_seq: RTL and testbench

- Interrupt and return sequencer for the program counter.
- Sits between the instruction decoder and the PC unit on the shared addr/data/re buses.
- In normal operation it passes decoder bus traffic straight through.
- On an accepted interrupt or a return-from-interrupt, it stalls the core and injects the PC load sequence itself: set-PC with the high byte, set-PC with the low byte, then an unconditional jump.
- It keeps a small nesting stack of return addresses and priorities.

---
 rtl/irq_vector_seq.sv | 161 ++++++++++++++++
 tb/tb_irq_vector_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_vector_seq.sv
// irq_vector_seq: interrupt entry / return sequencer for the program counter.
// In IDLE the decoder buses pass straight through. An accepted interrupt or a
// return stalls the core while this block injects set-PC-high, set-PC-low and
// an unconditional jump. A small LIFO keeps return addresses and priorities.
module irq_vector_seq #(
  parameter int                 DATA_WIDTH     = 8,
  parameter int                 ROM_ADDR_WIDTH = 16,
  parameter int                 NUM_IRQ        = 4,
  parameter int                 DEPTH          = 4,
  parameter logic [15:0]        VEC_BASE       = 16'h0004,
  parameter logic [3:0]         PC_ID          = 4'h1,
  parameter logic [3:0]         SRC_ID         = 4'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IRQ-1:0]        irq,
  input  logic [NUM_IRQ-1:0]        irq_en,
  input  logic                      gie,
  input  logic                      instr_boundary,
  input  logic                      reti,
  input  logic [ROM_ADDR_WIDTH-1:0] pc_value,
  input  logic [DATA_WIDTH-1:0]     core_addr_bus,
  input  logic [DATA_WIDTH-1:0]     core_data_bus,
  input  logic [DATA_WIDTH-1:0]     core_re,
  output logic [DATA_WIDTH-1:0]     addr_bus,
  output logic [DATA_WIDTH-1:0]     data_bus,
  output logic [DATA_WIDTH-1:0]     re,
  output logic                      stall,
  output logic [NUM_IRQ-1:0]        irq_ack,
  output logic                      in_service,
  output logic                      stack_err
);

  localparam int PRIO_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [DATA_WIDTH-1:0] LD_CODE   = DATA_WIDTH'({SRC_ID, PC_ID});
  localparam logic [DATA_WIDTH-1:0] JUMP_CODE = DATA_WIDTH'({PC_ID, PC_ID});
  localparam logic [DEPTH_W-1:0]    FULL      = DEPTH_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, LD_HI, LD_LO, JUMP} state_t;

  state_t                    state;
  logic [ROM_ADDR_WIDTH-1:0] target;
  logic [DEPTH_W-1:0]        depth;
  logic [DATA_WIDTH-1:0]     inj_addr;
  logic [DATA_WIDTH-1:0]     inj_data;

  logic [ROM_ADDR_WIDTH-1:0] stack_addr [DEPTH];
  logic [PRIO_W-1:0]         stack_prio [DEPTH];

  logic [NUM_IRQ-1:0]        pending;
  logic [PRIO_W-1:0]         win_idx;
  logic                      win_valid;
  logic [PTR_W-1:0]          top_ptr;
  logic [PTR_W-1:0]          push_ptr;
  logic [PRIO_W-1:0]         top_prio;
  logic                      prio_ok;
  logic                      do_accept;
  logic                      do_return;
  logic                      do_err;
  logic [ROM_ADDR_WIDTH-1:0] vector;
  logic [ROM_ADDR_WIDTH-1:0] next_target;
  logic [NUM_IRQ-1:0]        ack_onehot;

  // Pick the lowest-numbered enabled request and decide accept/return/error.
  // A reti seen in IDLE always takes precedence over a new interrupt.
  always_comb begin
    pending   = irq & irq_en;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_idx   = PRIO_W'(i);
        win_valid = 1'b1;
      end
    end
    top_ptr     = PTR_W'(depth - DEPTH_W'(1));
    push_ptr    = PTR_W'(depth);
    top_prio    = stack_prio[top_ptr];
    prio_ok     = (depth == '0) || (win_idx < top_prio);
    do_return   = (state == IDLE) && reti && (depth != '0);
    do_err      = (state == IDLE) && reti && (depth == '0);
    do_accept   = (state == IDLE) && !reti && gie && instr_boundary &&
                  win_valid && (depth < FULL) && prio_ok;
    vector      = VEC_BASE + ROM_ADDR_WIDTH'({win_idx, 2'b00});
    next_target = do_return ? stack_addr[top_ptr] : vector;
    ack_onehot  = NUM_IRQ'(1) << win_idx;
  end

  // Sequencer FSM: owns depth, target and every registered output, so an
  // asynchronous reset drops any partially injected sequence in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      depth      <= '0;
      target     <= '0;
      inj_addr   <= '0;
      inj_data   <= '0;
      stall      <= 1'b0;
      irq_ack    <= '0;
      in_service <= 1'b0;
      stack_err  <= 1'b0;
    end else begin
      irq_ack <= '0;
      case (state)
        IDLE: begin
          if (do_accept || do_return) begin
            target   <= next_target;
            inj_addr <= LD_CODE;
            inj_data <= next_target[ROM_ADDR_WIDTH-1 -: DATA_WIDTH];
            stall    <= 1'b1;
            state    <= LD_HI;
            if (do_accept) begin
              depth      <= depth + DEPTH_W'(1);
              in_service <= 1'b1;
              irq_ack    <= ack_onehot;
            end else begin
              depth      <= depth - DEPTH_W'(1);
              in_service <= (depth != DEPTH_W'(1));
            end
          end else if (do_err) begin
            stack_err <= 1'b1;
          end
        end
        LD_HI: begin
          inj_data <= target[DATA_WIDTH-1:0];
          state    <= LD_LO;
        end
        LD_LO: begin
          inj_addr <= JUMP_CODE;
          inj_data <= '0;
          state    <= JUMP;
        end
        JUMP: begin
          stall <= 1'b0;
          state <= IDLE;
        end
        default: begin
          stall <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Return-address stack storage; contents need no reset because depth
  // alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_accept) begin
      stack_addr[push_ptr] <= pc_value;
      stack_prio[push_ptr] <= win_idx;
    end
  end

  assign addr_bus = stall ? inj_addr : core_addr_bus;
  assign data_bus = stall ? inj_data : core_data_bus;
  assign re       = stall ? '0       : core_re;

endmodule

// File: tb/tb_irq_vector_seq.sv
// Testbench for irq_vector_seq: a directed table, hand-written nesting,
// edge-event and reset sequences, then randomized traffic, all compared
// against a queue-based reference model of the sequencer.
module tb_irq_vector_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq, irq_en;
  logic        gie, instr_boundary, reti;
  logic [15:0] pc_value;
  logic [7:0]  core_addr_bus, core_data_bus, core_re;
  logic [7:0]  addr_bus, data_bus, re;
  logic        stall, in_service, stack_err;
  logic [3:0]  irq_ack;

  int checks = 0;
  int fails  = 0;

  irq_vector_seq dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_en(irq_en), .gie(gie),
    .instr_boundary(instr_boundary), .reti(reti), .pc_value(pc_value),
    .core_addr_bus(core_addr_bus), .core_data_bus(core_data_bus),
    .core_re(core_re), .addr_bus(addr_bus), .data_bus(data_bus), .re(re),
    .stall(stall), .irq_ack(irq_ack), .in_service(in_service),
    .stack_err(stack_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Reference model: a stack of frames plus a queue of bus words still to be
  // injected. While the queue is non-empty the core is stalled.
  typedef struct {
    logic [15:0] addr;
    logic [1:0]  prio;
  } frame_t;

  frame_t     mstack[$];
  logic [7:0] inj_a[$];
  logic [7:0] inj_d[$];
  logic [3:0] m_ack;
  logic       m_err;

  function automatic void modelReset();
    mstack.delete();
    inj_a.delete();
    inj_d.delete();
    m_ack = 4'h0;
    m_err = 1'b0;
  endfunction

  function automatic void scheduleLoad(input logic [15:0] t);
    inj_a.push_back(8'h01); inj_d.push_back(t[15:8]);
    inj_a.push_back(8'h01); inj_d.push_back(t[7:0]);
    inj_a.push_back(8'h11); inj_d.push_back(8'h00);
  endfunction

  function automatic void modelStep();
    int     k;
    frame_t f;
    if (rst) begin
      modelReset();
      return;
    end
    m_ack = 4'h0;
    if (inj_a.size() > 0) begin
      void'(inj_a.pop_front());
      void'(inj_d.pop_front());
    end else if (reti) begin
      if (mstack.size() > 0) begin
        f = mstack.pop_back();
        scheduleLoad(f.addr);
      end else begin
        m_err = 1'b1;
      end
    end else if (gie && instr_boundary) begin
      k = -1;
      for (int i = 3; i >= 0; i--)
        if (irq[i] && irq_en[i]) k = i;
      if (k >= 0 && mstack.size() < 4 &&
          (mstack.size() == 0 || k < int'(mstack[$].prio))) begin
        f.addr = pc_value;
        f.prio = 2'(k);
        mstack.push_back(f);
        m_ack = 4'b0001 << k;
        scheduleLoad(16'h0004 + 16'(4 * k));
      end
    end
  endfunction

  function automatic logic [30:0] modelExpect();
    logic [7:0] ea, ed, er;
    logic       es;
    if (inj_a.size() > 0) begin
      ea = inj_a[0]; ed = inj_d[0]; er = 8'h00; es = 1'b1;
    end else begin
      ea = core_addr_bus; ed = core_data_bus; er = core_re; es = 1'b0;
    end
    return {ea, ed, er, es, m_ack, (mstack.size() != 0), m_err};
  endfunction

  function automatic logic [30:0] dutPack();
    return {addr_bus, data_bus, re, stall, irq_ack, in_service, stack_err};
  endfunction

  // Generic comparison used by every check in the bench
  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    checkValue(name, 32'(dutPack()), 32'(modelExpect()));
  endtask

  task automatic applyStimulus(input logic [3:0] i_irq, input logic i_reti,
                               input logic [15:0] i_pc, input logic [7:0] ca,
                               input logic [7:0] cd, input logic [7:0] cr);
    irq = i_irq; reti = i_reti; pc_value = i_pc;
    core_addr_bus = ca; core_data_bus = cd; core_re = cr;
  endtask

  // One clock: compare at the falling edge, advance the model on the rising
  // edge, and leave time 1 ns after it for the next stimulus.
  task automatic runCycle(input string name);
    @(negedge clk);
    checkOutput(name);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic resetCycle();
    rst = 1'b1;
    modelReset();
    runCycle("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  irq;
    logic        reti;
    logic [15:0] pc;
    logic [7:0]  ca, cd, cr;
    logic [7:0]  ea, ed, er;
    logic        es;
    logic [3:0]  eack;
    logic        eins;
  } vec_t;

  vec_t tbl[10];
  logic [3:0] saw_ack;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; irq = 4'h0; irq_en = 4'hF; gie = 1'b1; instr_boundary = 1'b1;
    reti = 1'b0; pc_value = 16'h0000;
    core_addr_bus = 8'h00; core_data_bus = 8'h00; core_re = 8'h00;
    modelReset();
    #1;
    checkOutput("reset state");
    @(posedge clk); modelStep(); #1;
    rst = 1'b0;

    // Passthrough, single interrupt on line 2 and its return
    tbl[0] = '{4'h0, 1'b0, 16'h0000, 8'h23, 8'h5A, 8'h01, 8'h23, 8'h5A, 8'h01, 1'b0, 4'h0, 1'b0};
    tbl[1] = '{4'h4, 1'b0, 16'h0123, 8'h23, 8'h5A, 8'h01, 8'h23, 8'h5A, 8'h01, 1'b0, 4'h0, 1'b0};
    tbl[2] = '{4'h0, 1'b0, 16'h0000, 8'hAA, 8'hBB, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 4'h4, 1'b1};
    tbl[3] = '{4'h0, 1'b0, 16'h0000, 8'hAA, 8'hBB, 8'hFF, 8'h01, 8'h0C, 8'h00, 1'b1, 4'h0, 1'b1};
    tbl[4] = '{4'h0, 1'b0, 16'h0000, 8'hAA, 8'hBB, 8'hFF, 8'h11, 8'h00, 8'h00, 1'b1, 4'h0, 1'b1};
    tbl[5] = '{4'h0, 1'b1, 16'h0000, 8'h23, 8'h5A, 8'h01, 8'h23, 8'h5A, 8'h01, 1'b0, 4'h0, 1'b1};
    tbl[6] = '{4'h0, 1'b0, 16'h0000, 8'hAA, 8'hBB, 8'hFF, 8'h01, 8'h01, 8'h00, 1'b1, 4'h0, 1'b0};
    tbl[7] = '{4'h0, 1'b0, 16'h0000, 8'hAA, 8'hBB, 8'hFF, 8'h01, 8'h23, 8'h00, 1'b1, 4'h0, 1'b0};
    tbl[8] = '{4'h0, 1'b0, 16'h0000, 8'hAA, 8'hBB, 8'hFF, 8'h11, 8'h00, 8'h00, 1'b1, 4'h0, 1'b0};
    tbl[9] = '{4'h0, 1'b0, 16'h0000, 8'h3C, 8'hC3, 8'h02, 8'h3C, 8'hC3, 8'h02, 1'b0, 4'h0, 1'b0};

    for (int r = 0; r < 10; r++) begin
      applyStimulus(tbl[r].irq, tbl[r].reti, tbl[r].pc, tbl[r].ca, tbl[r].cd, tbl[r].cr);
      @(negedge clk);
      checkValue($sformatf("table row %0d", r),
                 32'({addr_bus, data_bus, re, stall, irq_ack, in_service}),
                 32'({tbl[r].ea, tbl[r].ed, tbl[r].er, tbl[r].es, tbl[r].eack, tbl[r].eins}));
      checkOutput($sformatf("table model %0d", r));
      @(posedge clk); modelStep(); #1;
    end

    // Nesting: irq1 preempts irq2, irq3 must wait until depth returns to 0
    resetCycle();
    applyStimulus(4'h4, 1'b0, 16'h0200, 8'h10, 8'h20, 8'h30);
    runCycle("nest accept irq2");
    checkValue("nest ack irq2", 32'(irq_ack), 32'h4);
    repeat (3) runCycle("nest irq2 load");
    applyStimulus(4'h6, 1'b0, 16'h0300, 8'h10, 8'h20, 8'h30);
    runCycle("nest accept irq1");
    checkValue("nest ack irq1", 32'(irq_ack), 32'h2);
    runCycle("nest irq1 hi");
    checkValue("nest vector lo", 32'(data_bus), 32'h08);
    runCycle("nest irq1 lo");
    runCycle("nest irq1 jump");
    applyStimulus(4'h8, 1'b0, 16'h0400, 8'h10, 8'h20, 8'h30);
    saw_ack = 4'h0;
    repeat (6) begin
      runCycle("nest irq3 wait");
      saw_ack |= irq_ack;
    end
    checkValue("nest irq3 blocked", 32'(saw_ack), 32'h0);
    reti = 1'b1; runCycle("nest reti1"); reti = 1'b0;
    repeat (3) runCycle("nest reti1 load");
    checkValue("nest depth1 after reti", 32'(in_service), 32'h1);
    reti = 1'b1; runCycle("nest reti2"); reti = 1'b0;
    repeat (3) runCycle("nest reti2 load");
    runCycle("nest accept irq3");
    checkValue("nest ack irq3", 32'(irq_ack), 32'h8);
    repeat (3) runCycle("nest irq3 load");

    // Fill the stack with 3,2,1,0; further requests get no ack
    resetCycle();
    for (int n = 3; n >= 0; n--) begin
      applyStimulus(4'hF << n, 1'b0, 16'h1000 + 16'(n), 8'h00, 8'h00, 8'h00);
      repeat (4) runCycle("fill");
    end
    saw_ack = 4'h0;
    repeat (5) begin
      runCycle("full wait");
      saw_ack |= irq_ack;
    end
    checkValue("full no ack", 32'(saw_ack), 32'h0);

    // reti and irq0 together: return first, irq0 accepted after the jump
    resetCycle();
    applyStimulus(4'h2, 1'b0, 16'hBEEF, 8'h00, 8'h00, 8'h00);
    repeat (4) runCycle("edge irq1");
    applyStimulus(4'h1, 1'b1, 16'h5555, 8'h00, 8'h00, 8'h00);
    runCycle("edge reti+irq0");
    reti = 1'b0;
    checkValue("edge reti wins ack", 32'(irq_ack), 32'h0);
    checkValue("edge reti hi", 32'(data_bus), 32'hBE);
    repeat (3) runCycle("edge return load");
    runCycle("edge irq0 accept");
    checkValue("edge irq0 ack", 32'(irq_ack), 32'h1);
    irq = 4'h0;
    repeat (3) runCycle("edge irq0 load");
    reti = 1'b1; runCycle("edge reti pop"); reti = 1'b0;
    repeat (3) runCycle("edge pop load");
    reti = 1'b1; runCycle("edge empty reti"); reti = 1'b0;
    checkValue("stack_err set", 32'(stack_err), 32'h1);
    repeat (3) runCycle("stack_err hold");
    checkValue("stack_err sticky", 32'(stack_err), 32'h1);

    // Reset during LD_LO
    resetCycle();
    applyStimulus(4'h4, 1'b0, 16'h1234, 8'h66, 8'h77, 8'h88);
    runCycle("mid accept");
    runCycle("mid ld_hi");
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("mid reset outputs");
    checkValue("mid reset flags", 32'({stall, irq_ack, in_service, addr_bus}), 32'h066);
    @(posedge clk); modelStep(); #1;
    rst = 1'b0;
    runCycle("post reset accept");
    checkValue("post reset ack", 32'(irq_ack), 32'h4);
    repeat (4) runCycle("post reset load");

    // Randomized traffic against the model
    irq = 4'h0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        modelReset();
      end else begin
        rst = 1'b0;
      end
      gie            = ($urandom_range(0, 7) != 0);
      instr_boundary = ($urandom_range(0, 3) != 0);
      irq_en         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      irq            = ($urandom_range(0, 2) == 0) ? 4'($urandom) : irq;
      reti           = ($urandom_range(0, 5) == 0);
      pc_value       = 16'($urandom);
      core_addr_bus  = 8'($urandom);
      core_data_bus  = 8'($urandom);
      core_re        = 8'($urandom);
      runCycle("random");
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
